// File: rtl/dldo_pkg.sv
// Shared definitions for the digital LDO power-transistor controller.
//   - FSM state encodings (legacy-compatible 2-bit constants)
//   - mode_sel encodings
//   - LC_EXIT_CNT: identical comparator samples needed to leave LOCK
//   - therm(): count to thermometer code (bit i set for every i < n)
package dldo_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_COARSE = 2'd1;
  localparam state_t ST_FINE   = 2'd2;
  localparam state_t ST_LOCK   = 2'd3;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_PT_TEST   = 2'b00;
  localparam mode_t MODE_CTRL_TEST = 2'b01;
  localparam mode_t MODE_RUN       = 2'b10;  // 2'b11 is also a run mode

  localparam int unsigned LC_EXIT_CNT = 3;

  // Wide result; callers size-cast down to their leg count.
  function automatic logic [63:0] therm(input int unsigned n);
    logic [63:0] t;
    t = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      t[i] = (i < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/dldo_pt_ctrl_if.sv
// Controller-side signal bundle of the digital LDO.
//   master: LDO top / test logic (drives en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt)
//   slave : dldo_pt_ctrl (drives ctrl_out, pt_cnt, settled, sat_hi, sat_lo)
interface dldo_pt_ctrl_if #(
  parameter int unsigned ARRSZ = 9,
  parameter int unsigned CNTW  = 4
);
  logic             en;
  logic [1:0]       mode_sel;
  logic             cmp_in;
  logic             std_ctrl_in;
  logic [8:0]       std_pt_in_cnt;
  logic [ARRSZ-1:0] ctrl_out;
  logic [CNTW-1:0]  pt_cnt;
  logic             settled;
  logic             sat_hi;
  logic             sat_lo;

  modport master (
    output en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt,
    input  ctrl_out, pt_cnt, settled, sat_hi, sat_lo
  );

  modport slave (
    input  en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt,
    output ctrl_out, pt_cnt, settled, sat_hi, sat_lo
  );
endinterface

// File: rtl/dldo_sync2.sv
// Two-flop synchroniser for the comparator decision.
//   clk   : destination clock
//   reset : asynchronous, active-low; clears both flops
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module dldo_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/dldo_pt_ctrl.sv
// Digital LDO feedback controller: turns the comparator decision stream into an
// active-leg count with a coarse/fine search and limit-cycle detection, and drives
// the PMOS array with a registered thermometer code.
//   clk   : controller clock
//   reset : asynchronous, active-low
//   bus   : dldo_pt_ctrl_if.slave (en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt in;
//           ctrl_out, pt_cnt, settled, sat_hi, sat_lo out)
// Build option DLDO_LC_FREEZE_EN: when defined, a detected limit cycle enters LOCK and
// freezes the count; otherwise FINE keeps dithering and settled flags the limit cycle.
module dldo_pt_ctrl
  import dldo_pkg::*;
#(
  parameter int unsigned ARRSZ       = 9,
  parameter int unsigned CNTW        = 4,
  parameter int unsigned COARSE_STEP = 2,
  parameter int unsigned LC_WIN      = 4,
  parameter int unsigned RESET_CNT   = 0
) (
  input logic           clk,
  input logic           reset,
  dldo_pt_ctrl_if.slave bus
);

  localparam int unsigned AltW = $clog2(LC_WIN + 1);
  localparam logic [CNTW-1:0]  ArrCnt     = CNTW'(ARRSZ);
  localparam logic [CNTW:0]    ArrExt     = (CNTW + 1)'(ARRSZ);
  localparam logic [CNTW:0]    CoarseAmt  = (CNTW + 1)'(COARSE_STEP);
  localparam logic [CNTW:0]    FineAmt    = (CNTW + 1)'(1);
  localparam logic [AltW-1:0]  AltMax     = AltW'(LC_WIN);
  localparam logic [CNTW-1:0]  ResetCnt   = CNTW'(RESET_CNT);
  localparam logic [ARRSZ-1:0] ResetCtrl  = ARRSZ'(therm(RESET_CNT));
  localparam logic             ResetSatHi = (RESET_CNT == ARRSZ);
  localparam logic             ResetSatLo = (RESET_CNT == 0);

  // One guard bit keeps the add/subtract from wrapping before the clamp.
  function automatic logic [CNTW-1:0] step_cnt(input logic [CNTW-1:0] cnt, input logic up,
                                               input logic [CNTW:0] amt);
    logic [CNTW:0] ext;
    if (up) begin
      ext = {1'b0, cnt} + amt;
      if (ext > ArrExt) ext = ArrExt;
    end else begin
      ext = {1'b0, cnt} - amt;
      if (ext[CNTW]) ext = '0;
    end
    return ext[CNTW-1:0];
  endfunction

  logic             cmp_src;
  logic             cmp_s;
  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [ARRSZ-1:0] ctrl_q, ctrl_d;
  logic             settled_q, settled_d;
  logic             sat_hi_q, sat_lo_q;
  logic [AltW-1:0]  alt_q, alt_d;
  logic             dir_q, dir_d;          // direction of the previous step, 1 = up
  logic             dir_vld_q, dir_vld_d;  // a previous step exists in this search
  logic             held;
  logic             rev;
  logic [CNTW-1:0]  load_cnt;
  logic             lock_exit;

  assign cmp_src = (bus.mode_sel == MODE_CTRL_TEST) ? bus.std_ctrl_in : bus.cmp_in;

  dldo_sync2 u_cmp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cmp_src),
    .q     (cmp_s)
  );

  assign load_cnt = (bus.std_pt_in_cnt > 9'(ARRSZ)) ? ArrCnt : bus.std_pt_in_cnt[CNTW-1:0];

  // A step into a rail is held and is never treated as a reversal.
  assign held = cmp_s ? (cnt_q == ArrCnt) : (cnt_q == '0);
  assign rev  = dir_vld_q && (cmp_s != dir_q) && !held;

`ifdef DLDO_LC_FREEZE_EN
  localparam int unsigned HistW = LC_EXIT_CNT - 1;
  logic [HistW-1:0] hist_q;  // previous cmp_s samples, [0] is the newest

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[HistW-2:0], cmp_s};
    end
  end

  assign lock_exit = (hist_q == {HistW{cmp_s}});
`else
  assign lock_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alt_d     = alt_q;
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
    if (bus.mode_sel == MODE_PT_TEST) begin
      state_d   = ST_IDLE;
      cnt_d     = load_cnt;
      alt_d     = '0;
      dir_vld_d = 1'b0;
    end else if (!bus.en) begin
      state_d   = ST_IDLE;
      alt_d     = '0;
      dir_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_COARSE;
        end
        ST_COARSE: begin
          dir_d     = cmp_s;
          dir_vld_d = 1'b1;
          if (rev) begin
            // Overshoot detected: the reversing step is already a fine one.
            cnt_d   = step_cnt(cnt_q, cmp_s, FineAmt);
            alt_d   = '0;
            state_d = ST_FINE;
          end else begin
            cnt_d = step_cnt(cnt_q, cmp_s, CoarseAmt);
          end
        end
        ST_FINE: begin
          dir_d     = cmp_s;
          dir_vld_d = 1'b1;
          cnt_d     = step_cnt(cnt_q, cmp_s, FineAmt);
          if (rev) begin
            alt_d = (alt_q == AltMax) ? alt_q : alt_q + 1'b1;
          end else begin
            alt_d = '0;
          end
`ifdef DLDO_LC_FREEZE_EN
          if (alt_d == AltMax) state_d = ST_LOCK;
`endif
        end
`ifdef DLDO_LC_FREEZE_EN
        ST_LOCK: begin
          // A steady comparator means the load moved; resume dithering with this step.
          if (lock_exit) begin
            dir_d   = cmp_s;
            cnt_d   = step_cnt(cnt_q, cmp_s, FineAmt);
            alt_d   = '0;
            state_d = ST_FINE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_d = ARRSZ'(therm(32'(cnt_d)));
`ifdef DLDO_LC_FREEZE_EN
    settled_d = (state_d == ST_LOCK);
`else
    settled_d = (alt_d >= AltMax);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= ResetCnt;
      ctrl_q    <= ResetCtrl;
      settled_q <= 1'b0;
      sat_hi_q  <= ResetSatHi;
      sat_lo_q  <= ResetSatLo;
      alt_q     <= '0;
      dir_q     <= 1'b0;
      dir_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      settled_q <= settled_d;
      sat_hi_q  <= (cnt_d == ArrCnt);
      sat_lo_q  <= (cnt_d == '0);
      alt_q     <= alt_d;
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
    end
  end

  assign bus.ctrl_out = ctrl_q;
  assign bus.pt_cnt   = cnt_q;
  assign bus.settled  = settled_q;
  assign bus.sat_hi   = sat_hi_q;
  assign bus.sat_lo   = sat_lo_q;

endmodule

// File: tb/tb_dldo_pt_ctrl.sv
// Directed bench for dldo_pt_ctrl (default parameters: 9 legs, coarse step 2, window 4).
module tb_dldo_pt_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dldo_pt_ctrl_if #(.ARRSZ(9), .CNTW(4)) bus ();

  dldo_pt_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [8:0] std_cnt;
    int         exp_cnt;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int cnt, input logic settled);
    logic [8:0] exp_ctrl;
    exp_ctrl = '0;
    for (int i = 0; i < cnt; i++) exp_ctrl[i] = 1'b1;
    check({tag, ".pt_cnt"}, bus.pt_cnt, cnt);
    check({tag, ".ctrl_out"}, bus.ctrl_out, exp_ctrl);
    check({tag, ".sat_hi"}, bus.sat_hi, (cnt == 9) ? 1 : 0);
    check({tag, ".sat_lo"}, bus.sat_lo, (cnt == 0) ? 1 : 0);
    check({tag, ".settled"}, bus.settled, settled);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    bus.en            = 1'b0;
    bus.mode_sel      = 2'b10;
    bus.cmp_in        = 1'b0;
    bus.std_ctrl_in   = 1'b0;
    bus.std_pt_in_cnt = '0;
    tick();
    reset = 1'b1;
  endtask

  vec_t vecs[11];
  logic seq_src[20];
  int   seq_cnt[20];
  logic seq_set[20];

  initial begin
    vecs = '{
      '{2'b01, 1'b0, 9'd0,   0},
      '{2'b00, 1'b0, 9'd3,   3},
      '{2'b00, 1'b1, 9'd300, 9},
      '{2'b00, 1'b1, 9'd0,   0},
      '{2'b00, 1'b0, 9'd9,   9},
      '{2'b00, 1'b0, 9'd10,  9},
      '{2'b00, 1'b0, 9'd8,   8},
      '{2'b00, 1'b0, 9'd511, 9},
      '{2'b10, 1'b0, 9'd0,   9},
      '{2'b00, 1'b0, 9'd1,   1},
      '{2'b11, 1'b0, 9'd0,   1}
    };
    seq_src = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef DLDO_LC_FREEZE_EN
    seq_cnt = '{0, 2, 4, 6, 5, 6, 5, 6, 5, 5, 5, 5, 4, 3, 2, 1, 0, 0, 0, 0};
    seq_set = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    seq_cnt = '{0, 2, 4, 6, 5, 6, 5, 6, 5, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    seq_set = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    bus.en            = 1'b0;
    bus.mode_sel      = 2'b10;
    bus.cmp_in        = 1'b0;
    bus.std_ctrl_in   = 1'b0;
    bus.std_pt_in_cnt = '0;

    // Reset held low across edges, then released with en = 0.
    #2 reset = 1'b0;
    #1 expect_state("rst_async", 0, 1'b0);
    tick();
    tick();
    expect_state("rst_held", 0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    expect_state("rst_release", 0, 1'b0);

    // Mode 00 loads, saturation, and hold with en = 0 in run modes.
    foreach (vecs[i]) begin
      bus.mode_sel      = vecs[i].mode;
      bus.en            = vecs[i].en;
      bus.std_pt_in_cnt = vecs[i].std_cnt;
      tick();
      expect_state($sformatf("vec%0d", i), vecs[i].exp_cnt, 1'b0);
    end

    // Mode 00 -> run starts COARSE from the loaded count; en drop holds it.
    bus.mode_sel      = 2'b00;
    bus.std_pt_in_cnt = 9'd4;
    bus.cmp_in        = 1'b1;
    tick();
    tick();
    expect_state("load4", 4, 1'b0);
    bus.mode_sel = 2'b10;
    bus.en       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state($sformatf("from_load%0d", i), (i == 0) ? 4 : (i == 1) ? 6 : (i == 2) ? 8 : 9,
                   1'b0);
    end
    bus.en = 1'b0;
    tick();
    expect_state("en_drop", 9, 1'b0);

    // Coarse ramp with the comparator held high.
    apply_reset();
    bus.cmp_in = 1'b1;
    tick();
    tick();
    expect_state("ramp_pre", 0, 1'b0);
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_state($sformatf("ramp%0d", i), (i < 5) ? 2 * i : 9, 1'b0);
    end

    // Search, limit cycle near 5, then load step pulling the count to 0.
    apply_reset();
    bus.cmp_in = 1'b1;
    tick();
    tick();
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.cmp_in = seq_src[i];
      tick();
      expect_state($sformatf("search%0d", i), seq_cnt[i], seq_set[i]);
    end

    // Controller-test mode uses std_ctrl_in; reset lands asynchronously mid-ramp.
    apply_reset();
    bus.mode_sel    = 2'b01;
    bus.std_ctrl_in = 1'b1;
    bus.cmp_in      = 1'b0;
    tick();
    tick();
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("ctest%0d", i), 2 * i, 1'b0);
    end
    #2 reset = 1'b0;
    #1 expect_state("mid_rst_async", 0, 1'b0);
    tick();
    expect_state("mid_rst_held", 0, 1'b0);
    reset = 1'b1;
    bus.en = 1'b0;
    tick();
    tick();
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("ctest_again%0d", i), 2 * i, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dldo_pt_ctrl.md
Name: dldo_pt_ctrl

Overview:
- Digital LDO feedback controller.
- Sits between the clocked comparator (cmp_out) and the PMOS power-transistor array.
- Converts the comparator decision stream into an active-leg count, then into a registered thermometer code (ctrl_out).
- Uses an adaptive coarse/fine search with limit-cycle lock detection.
- Also provides the test-mode overrides used by the LDO top.

Parameters:
- ARRSZ, 9: number of PT legs; width of ctrl_out.
- CNTW, 4: count width; must be at least $clog2(ARRSZ+1).
- COARSE_STEP, 2: legs added or removed per cycle in COARSE.
- LC_WIN, 4: consecutive direction alternations in FINE that declare lock.
- RESET_CNT, 0: pt_cnt value after reset; must be ≤ ARRSZ.

Ports:
- clk, input, 1: controller clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- en, input, 1: controller enable for run modes.
- mode_sel, input, 2: 00 PT-array test; 01 controller test; 10/11 LDO run.
- cmp_in, input, 1: comparator output; 1 = VOUT below VREF, so more legs are required.
- std_ctrl_in, input, 1: substitute comparator input in mode 01.
- std_pt_in_cnt, input, 9: direct leg count in mode 00.
- ctrl_out, output, ARRSZ: thermometer; bit i = 1 turns leg i on.
- pt_cnt, output, CNTW: current active-leg count.
- settled, output, 1: 1 while in LOCK.
- sat_hi, output, 1: pt_cnt == ARRSZ.
- sat_lo, output, 1: pt_cnt == 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, pt_cnt = RESET_CNT, ctrl_out = thermometer(RESET_CNT).
  - settled = 0; synchroniser flops = 0; alternation counter = 0.
- Comparator source:
  - mode 01 selects std_ctrl_in; all other modes select cmp_in.
  - The source passes through a 2-flop synchroniser. cmp_s lags the source by 2 clk cycles.
- Outputs:
  - ctrl_out and pt_cnt are registered together, so ctrl_out always equals thermometer(pt_cnt).
  - sat_hi, sat_lo and settled are registered in the same clk edge.
- Arithmetic:
  - next count = pt_cnt ± step, clamped to [0, ARRSZ].
  - Compute with one guard bit so there is no wrap-around.
- Mode 00:
  - pt_cnt <= min(std_pt_in_cnt, ARRSZ) every cycle; state forced to IDLE.
  - Values above ARRSZ saturate (e.g. 9'd300 gives 9 with ARRSZ = 9).
- Modes 01/10/11 with en = 0: state IDLE, pt_cnt held.
- FSM states (encoded in package):
  - IDLE: en=1 and mode≠00 → COARSE.
  - COARSE:
    - Each cycle pt_cnt += COARSE_STEP if cmp_s = 1, else −= COARSE_STEP.
    - The first direction reversal relative to the previous step → FINE, alternation counter = 0.
  - FINE:
    - Step ±1.
    - A reversal increments the alternation counter; a same-direction step clears it.
    - Counter reaches LC_WIN → LOCK.
  - LOCK:
    - pt_cnt held; settled = 1.
    - 3 consecutive identical cmp_s samples → FINE, settled = 0.
- Saturation:
  - At a clamp, a step toward the rail holds the count.
  - A held step counts as same-direction, not a reversal.
- Simultaneous events:
  - en deassert or a mode change has priority over FSM transitions and takes effect next edge.
  - A mode change 00 → run starts COARSE from the loaded count.
- Reset mid-operation returns immediately to the reset values above; no pending step completes.

Optional Feature:
- Macro DLDO_LC_FREEZE_EN.
- Defined: LOCK state exists as described; the count is frozen to eliminate ripple.
- Undefined:
  - No LOCK state; FINE keeps stepping ±1 forever.
  - settled = 1 while the alternation counter ≥ LC_WIN, else 0.

Decomposition:
- Package dldo_pkg:
  - state enum (IDLE, COARSE, FINE, LOCK).
  - mode_sel encodings (MODE_PT_TEST, MODE_CTRL_TEST, MODE_RUN).
  - LC_EXIT_CNT = 3.
  - thermometer conversion function.
- Sub-module dldo_sync2: 2-flop synchroniser with async active-low reset; instanced once on the comparator path.

Test Plan:
1. Reset held low with RESET_CNT = 0 → ctrl_out = 0, pt_cnt = 0, sat_lo = 1, settled = 0. Release → outputs remain 0 while en = 0.
2. Mode 00, std_pt_in_cnt = 3 → next edge ctrl_out = 9'b000000111. Then std_pt_in_cnt = 300 → ctrl_out = 9'h1FF, sat_hi = 1.
3. Mode 10, en = 1, cmp_in held 1 → pt_cnt 0,2,4,6,8,9 after the 2-cycle sync latency. Stays 9, sat_hi = 1, no FINE entry.
4. Mode 10, cmp_in toggling every cycle with equilibrium near 5 → COARSE→FINE after the first reversal. settled = 1 after LC_WIN = 4 alternations; pt_cnt then constant (with DLDO_LC_FREEZE_EN).
5. From LOCK, cmp_in held 0 for 3 synced samples → settled drops, pt_cnt decrements by 1 per cycle down to 0, sat_lo = 1.
6. Mode 01, std_ctrl_in = 1, cmp_in = 0 → count rises as in scenario 3. Assert reset mid-ramp → outputs return to reset values asynchronously.
